// File: rtl/logic_unit_pipe.sv
// One-stage registered bitwise logic unit with valid/ready handshake and a
// multi-beat accumulate mode that folds a packet of operands into one result.

module logic_unit_bit (
  input  logic       x,
  input  logic       y,
  input  logic [2:0] op,
  output logic       f
);
  always_comb begin
    case (op)
      3'b000:  f = x & y;
      3'b001:  f = x | y;
      3'b010:  f = x ^ y;
      3'b011:  f = ~(x | y);
      3'b100:  f = ~(x & y);
      3'b101:  f = ~(x ^ y);
      3'b110:  f = ~x;
      default: f = x;
    endcase
  end
endmodule

module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);
  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
  } out_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  out_t             out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] fx, fy, fn;
  logic [WIDTH-1:0] new_res;
  logic             fire, consume, produce;

  // One function evaluator serves both modes: an active packet folds acc with a.
  assign fx = (acc_mode && state_q == ACCUM) ? acc_q : a;
  assign fy = acc_mode ? a : b;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic_unit_bit u_bit (.x(fx[i]), .y(fy[i]), .op(op), .f(fn[i]));
  end

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign fire     = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = consume ? 1'b0 : out_valid_q;
    produce     = 1'b0;
    new_res     = fn;
    if (fire) begin
      if (!acc_mode) begin
        produce = 1'b1;
      end else if (state_q == IDLE) begin
        if (last) begin
          produce = 1'b1;
          new_res = a;
        end else begin
          acc_d   = a;
          state_d = ACCUM;
        end
      end else if (last) begin
        produce = 1'b1;
        state_d = IDLE;
      end else begin
        acc_d = fn;
      end
    end
    if (produce) begin
      out_d.result = new_res;
      out_d.zero   = ~|new_res;
      out_d.parity = ^new_res;
      out_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = out_q.result;
  assign zero      = out_q.zero;
  assign parity    = out_q.parity;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed plus randomized checks of logic_unit_pipe (WIDTH=8) against a
// packet-level reference model that folds each accumulate packet on its last beat.

module tb_logic_unit_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         acc_mode, last;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         zero, parity;

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .last(last),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .parity(parity)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
  } beat_t;

  int           checks = 0;
  int           errors = 0;
  logic         exp_ov;
  logic [W-1:0] exp_res;
  beat_t        pkt[$];

  function automatic logic [W-1:0] ref_f(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    case (f)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return ~(x & y);
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  // A packet's value is its first operand folded left through the rest.
  function automatic logic [W-1:0] fold_pkt();
    logic [W-1:0] r;
    r = pkt[0].a;
    for (int i = 1; i < pkt.size(); i++) r = ref_f(pkt[i].op, r, pkt[i].a);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_ov  = 1'b0;
    exp_res = '0;
    pkt.delete();
  endtask

  // One clock cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic cyc(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic [2:0] iop, input logic iam, input logic ilast, input logic ordy);
    logic f, c;
    beat_t bt;
    in_valid = iv; a = ia; b = ib; op = iop; acc_mode = iam; last = ilast; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, (!exp_ov || ordy));
    f = iv && (!exp_ov || ordy);
    c = exp_ov && ordy;
    @(posedge clk); #1;
    if (c) exp_ov = 1'b0;
    if (f) begin
      if (!iam) begin
        exp_res = ref_f(iop, ia, ib);
        exp_ov  = 1'b1;
      end else begin
        bt.op = iop; bt.a = ia;
        pkt.push_back(bt);
        if (ilast) begin
          exp_res = fold_pkt();
          exp_ov  = 1'b1;
          pkt.delete();
        end
      end
    end
    chk("out_valid", out_valid, exp_ov);
    chk("result", result, exp_res);
    chk("zero", zero, (exp_res == '0));
    chk("parity", parity, ^exp_res);
  endtask

  logic [W-1:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A, 8'hC5};
    in_valid = 0; a = 0; b = 0; op = 0; acc_mode = 0; last = 0; out_ready = 1;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_zero", zero, 1'b0);
    chk("rst_parity", parity, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;

    // Basic OR and XOR
    cyc(1, 8'hF0, 8'h0F, 3'd1, 0, 0, 1);
    chk("or_res", result, 8'hFF); chk("or_zero", zero, 0); chk("or_par", parity, 0);
    cyc(1, 8'hAA, 8'hAA, 3'd2, 0, 0, 1);
    chk("xor_res", result, 8'h00); chk("xor_zero", zero, 1);

    // Function sweep, back to back
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'hC5, 8'h3A, 3'(i), 0, 0, 1);
      chk("sweep_valid", out_valid, 1'b1);
      chk("sweep_res", result, sweep_exp[i]);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Backpressure
    cyc(1, 8'h01, 8'h02, 3'd1, 0, 0, 0);
    chk("bp_first", result, 8'h03);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'h30, 8'h0C, 3'd1, 0, 0, 0);
      chk("bp_hold", result, 8'h03);
      chk("bp_ready", in_ready, 1'b0);
    end
    cyc(1, 8'h30, 8'h0C, 3'd1, 0, 0, 1);
    chk("bp_second", result, 8'h3C);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("bp_drain", out_valid, 1'b0);

    // Accumulate OR then AND packets
    cyc(1, 8'h01, 0, 3'd1, 1, 0, 1);
    cyc(1, 8'h02, 0, 3'd1, 1, 0, 1);
    chk("acc_no_out", out_valid, 1'b0);
    cyc(1, 8'h04, 0, 3'd1, 1, 1, 1);
    chk("acc_or", result, 8'h07);
    cyc(1, 8'hFF, 0, 3'd0, 1, 0, 1);
    cyc(1, 8'h0F, 0, 3'd0, 1, 0, 1);
    cyc(1, 8'h3C, 0, 3'd0, 1, 1, 1);
    chk("acc_and", result, 8'h0C); chk("acc_and_zero", zero, 0); chk("acc_and_par", parity, 0);

    // Single-beat packet, then normal beat interleaved into a packet
    cyc(1, 8'h81, 0, 3'd0, 1, 1, 1);
    chk("single", result, 8'h81); chk("single_par", parity, 0);
    cyc(1, 8'h01, 0, 3'd1, 1, 0, 1);
    cyc(1, 8'h10, 8'h01, 3'd1, 0, 0, 1);
    chk("interleave_norm", result, 8'h11);
    cyc(1, 8'h80, 0, 3'd1, 1, 1, 1);
    chk("interleave_pkt", result, 8'h81);

    // Async reset mid-packet while a result is pending
    cyc(1, 8'hF0, 0, 3'd1, 1, 0, 1);
    cyc(1, 8'h0F, 0, 3'd1, 1, 0, 1);
    cyc(1, 8'h55, 0, 3'd7, 0, 0, 0);
    chk("pre_rst_valid", out_valid, 1'b1);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_result", result, 8'h00);
    chk("mid_rst_ready", in_ready, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 8'h01, 0, 3'd1, 1, 1, 1);
    chk("post_rst_pkt", result, 8'h01);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 3'($urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered bitwise logic unit for the CPU datapath. It generalises the single-bit OR primitive in three ways: it operates on WIDTH-bit operands, it selects one of eight logic functions per beat, and it has a valid/ready handshake on both sides. An accumulate mode folds a multi-beat stream of operands into one result, which serves reduction-style instructions and mask building. It sits between operand fetch and writeback as a one-stage pipelined unit.

## Interface
- WIDTH, 32, operand/result width in bits (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  unit accepts beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored in accumulate mode)
- op  input  3  function select
- acc_mode  input  1  beat belongs to an accumulate packet
- last  input  1  final beat of accumulate packet (ignored when acc_mode=0)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered, result==0
- parity  output  1  registered, XOR-reduce of result

## Operation
- Beat accepted ("fire") when in_valid && in_ready; output consumed when out_valid && out_ready.
- f(x,y) by op: 000 x&y, 001 x|y, 010 x^y, 011 ~(x|y), 100 ~(x&y), 101 ~(x^y), 110 ~x, 111 x. Pure bitwise, no carries, all WIDTH bits.
- Normal mode (acc_mode=0): on fire, result<=f(a,b), zero/parity updated from the same value, out_valid<=1. The accumulator is not touched.
- Accumulate mode (acc_mode=1): two-state FSM, IDLE / ACCUM (acc_active flag).
  - IDLE, fire, last=0: acc<=a, go to ACCUM. No output.
  - IDLE, fire, last=1: single-beat packet, result<=a, out_valid<=1, stay IDLE.
  - ACCUM, fire, last=0: acc<=f(acc,a) using that beat's op. Stay ACCUM. No output.
  - ACCUM, fire, last=1: result<=f(acc,a), out_valid<=1, go to IDLE.
- A normal-mode beat arriving while in ACCUM is processed as a normal beat. The FSM state and acc are preserved, and the packet continues with the next acc_mode=1 beat.
- Output register is a single entry. result, zero and parity hold stable while out_valid=1 && out_ready=0.

## Timing
- Reset (async assert, sync release): out_valid=0, result=0, zero=0, parity=0, acc=0, FSM=IDLE. in_ready=0 while rst=1.
- in_ready = !rst && (!out_valid || out_ready). It is combinational from out_ready, and uniform for all beats including non-last accumulate beats.
- Latency: a normal beat fired in cycle N gives out_valid=1 with its result in cycle N+1. An accumulate packet's result appears the cycle after its last beat fires.
- Throughput: 1 beat/cycle when out_ready=1. When consume and fire happen in the same cycle, out_valid stays 1 and result takes the new value.
- Consume without fire: out_valid<=0, and result/zero/parity hold their last values.
- Non-last accumulate beat fired while out_valid=1 && out_ready=1: out_valid<=0 and acc updates.
- rst asserted mid-packet: acc and the partial packet are discarded. The next acc_mode=1 beat starts a new packet from IDLE.

## Test plan
- WIDTH=8, out_ready=1; a=0xF0, b=0x0F, op=001 -> next cycle out_valid=1, result=0xFF, zero=0, parity=0. Then op=010, a=b=0xAA -> result=0x00, zero=1, parity=0.
- Function sweep: a=0xC5, b=0x3A, op=000..111 back-to-back -> results 0x00, 0xFF, 0xFF, 0x00, 0xFF, 0x00, 0x3A, 0xC5 on 8 consecutive cycles, with no gaps.
- Backpressure: out_ready=0, fire a=0x01|b=0x02 (op=001) -> result=0x03 held and in_ready=0 for 5 cycles while a second beat waits. Raise out_ready -> 0x03 consumed and the second result appears the following cycle.
- Accumulate: op=001 beats 0x01, 0x02, 0x04(last) -> exactly one out_valid pulse with result=0x07. Then op=000 beats 0xFF, 0x0F, 0x3C(last) -> result=0x0C, zero=0, parity=0.
- Single-beat packet: acc_mode=1, last=1, a=0x81 -> result=0x81, parity=0. An interleaved normal beat (0x10|0x01) mid-packet -> its own result 0x11, and the packet's final result is unaffected.
- Reset mid-packet: two OR beats 0xF0, 0x0F, then async rst pulse between clock edges -> out_valid=0, result=0 immediately. A new packet 0x01(last) then gives result=0x01, not 0xFF.
